// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

  // Per-channel edge selection, encoded exactly as it appears on mode_i.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Width of the debounce counter. It must hold 0..DEB_CYCLES-1 and is never
  // narrower than one bit, so DEB_CYCLES of 1 or 2 both give a 1-bit counter.
  function automatic int calc_dcnt_w(input int deb_cycles);
    if (deb_cycles <= 2) begin
      return 1;
    end
    return $clog2(deb_cycles);
  endfunction

endpackage : edge_det_pkg

// File: rtl/edge_det_ch.sv
// One edge-detector channel: synchroniser, debounce filter, edge detect,
// sticky flag and saturating event counter.
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int                DCNT_W   = calc_dcnt_w(DEB_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic       sync_s;
  logic       rise;
  logic       fall;
  logic       det;
  edge_mode_e mode;

  // mode_i is deliberately unregistered: a new mode acts on the very next edge.
  assign mode   = edge_mode_e'(mode_i);
  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = filt_q & ~filt_prev_q;
  assign fall   = ~filt_q & filt_prev_q;

  // Next-state logic: shift the synchroniser, run the debounce counter,
  // qualify edges by mode and update the sticky flag and event counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sync_d   = SYNC_STAGES'({sync_q, sig_i});
    dcnt_d   = dcnt_q;
    filt_d   = filt_q;
    det      = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    // Debounce: filt only follows s after DEB_CYCLES consecutive mismatches;
    // any agreement in between restarts the count.
    if (sync_s == filt_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      filt_d = sync_s;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end

    case (mode)
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      EDGE_BOTH: det = rise | fall;
      default:   det = 1'b0;
    endcase
    pulse_d = det;

    // A detected edge wins over a clear; when both coincide the event that
    // arrived with the clear is still counted.
    if (det) begin
      sticky_d = 1'b1;
      if (clr_i) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr_i) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // State registers; reset clears everything, including mid-debounce progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      sync_q      <= '0;
      dcnt_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      dcnt_q      <= dcnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      pulse_q     <= pulse_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o  = filt_q;
  assign pulse_o  = pulse_q;
  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;

endmodule : edge_det_ch

// File: rtl/multi_edge_det.sv
// Multi-channel synchronising, debouncing edge detector. Each channel is an
// independent edge_det_ch; this level only slices the packed buses.
module multi_edge_det
  import edge_det_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH-1:0]       pulse_o,
  output logic [NUM_CH-1:0]       sticky_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o
);

  // One channel per input bit; channel i owns mode bits [2i+:2] and counter
  // bits [i*CNT_W+:CNT_W].
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_i    (sig_in[i]),
      .mode_i   (mode_i[2*i +: 2]),
      .clr_i    (clr_i[i]),
      .level_o  (level_o[i]),
      .pulse_o  (pulse_o[i]),
      .sticky_o (sticky_o[i]),
      .cnt_o    (cnt_o[i*CNT_W +: CNT_W])
    );
  end : g_ch

endmodule : multi_edge_det

// File: tb/tb_multi_edge_det.sv
// Bench for multi_edge_det: directed scenarios plus a randomized run checked
// against a window-based behavioural model of each channel.
module tb_multi_edge_det;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
  localparam int CNT_W       = 2;
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam logic [63:0] WIN_MASK = (64'd1 << DEB_CYCLES) - 64'd1;

  logic                    clk    = 1'b0;
  logic                    rst_n  = 1'b0;
  logic [NUM_CH-1:0]       sig_in = '0;
  logic [2*NUM_CH-1:0]     mode_i = '1;
  logic [NUM_CH-1:0]       clr_i  = '0;
  logic [NUM_CH-1:0]       level_o;
  logic [NUM_CH-1:0]       pulse_o;
  logic [NUM_CH-1:0]       sticky_o;
  logic [NUM_CH*CNT_W-1:0] cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  multi_edge_det #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .mode_i   (mode_i),
    .clr_i    (clr_i),
    .level_o  (level_o),
    .pulse_o  (pulse_o),
    .sticky_o (sticky_o),
    .cnt_o    (cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural model. Raw samples and post-sync samples are kept as bit
  // histories (bit 0 = newest). The filtered level flips once the newest
  // DEB_CYCLES synchronised samples all disagree with it; the pulse follows
  // one edge after a flip, qualified by the mode seen on that edge.
  logic [63:0]       m_raw   [NUM_CH];
  logic [63:0]       m_shist [NUM_CH];
  int                m_chg   [NUM_CH];
  int                m_cnt   [NUM_CH];
  logic [NUM_CH-1:0] m_filt   = '0;
  logic [NUM_CH-1:0] m_pulse  = '0;
  logic [NUM_CH-1:0] m_sticky = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_raw[c] = '0; m_shist[c] = '0; m_chg[c] = 0; m_cnt[c] = 0;
      end
      m_filt = '0; m_pulse = '0; m_sticky = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic       s;
        logic       det;
        logic [1:0] md;
        m_raw[c] = {m_raw[c][62:0], sig_in[c]};
        s   = m_raw[c][SYNC_STAGES];
        md  = mode_i[2*c +: 2];
        det = (m_chg[c] == 1 && md[0]) || (m_chg[c] == 2 && md[1]);
        m_pulse[c] = det;
        if (det) begin
          m_sticky[c] = 1'b1;
          m_cnt[c] = clr_i[c] ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
        end else if (clr_i[c]) begin
          m_sticky[c] = 1'b0;
          m_cnt[c] = 0;
        end
        m_shist[c] = {m_shist[c][62:0], s};
        if ((m_shist[c] & WIN_MASK) == (m_filt[c] ? 64'd0 : WIN_MASK)) begin
          m_filt[c] = ~m_filt[c];
          m_chg[c]  = m_filt[c] ? 1 : 2;
        end else begin
          m_chg[c] = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sig_in = '0; mode_i = '1; clr_i = '0;
    cyc(3);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      n_tests++;
      if (level_o !== '0 || pulse_o !== '0 || sticky_o !== '0 || cnt_o !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: level=%b pulse=%b sticky=%b cnt=%h, required all zero",
                 k, level_o, pulse_o, sticky_o, cnt_o);
      end
    end
  endtask

  task automatic test_latency();
    mode_i[1:0] = 2'b01;
    sig_in[0]   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      n_tests++;
      if (level_o[0] !== (k >= 6) || pulse_o[0] !== (k == 7) || pulse_o[NUM_CH-1:1] !== '0) begin
        n_fail++;
        $display("FAIL latency step %0d: level0=%b pulse=%b, required level0=%b pulse=%b",
                 k, level_o[0], pulse_o, (k >= 6), {3'b000, (k == 7)});
      end
    end
    n_tests++;
    if (cnt_o[CNT_W-1:0] !== CNT_W'(1) || sticky_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_count: cnt0=%0d sticky0=%b, required 1 and 1", cnt_o[CNT_W-1:0], sticky_o[0]);
    end
  endtask

  task automatic test_glitch();
    int np = 0, nr = 0, nf = 0;
    logic seen = 1'b0;
    sig_in[1] = 1'b1; cyc(3); sig_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      np += int'(pulse_o[1]);
      seen |= level_o[1];
    end
    n_tests++;
    if (np != 0 || seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: pulses=%0d level_seen=%b, required 0 and 0", np, seen);
    end
    sig_in[1] = 1'b1; cyc(4); sig_in[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (pulse_o[1] && level_o[1]) nr++;
      if (pulse_o[1] && !level_o[1]) nf++;
    end
    n_tests++;
    if (nr != 1 || nf != 1) begin
      n_fail++;
      $display("FAIL glitch_edges: rise=%0d fall=%0d, required 1 and 1", nr, nf);
    end
    n_tests++;
    if (cnt_o[CNT_W +: CNT_W] !== CNT_W'(2) || level_o[1] !== 1'b0 || sticky_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_count: cnt1=%0d level1=%b sticky1=%b, required 2, 0, 1",
               cnt_o[CNT_W +: CNT_W], level_o[1], sticky_o[1]);
    end
  endtask

  task automatic test_mode();
    int np = 0, bad = 0, ntog = 0;
    logic prev;
    mode_i[5:4] = 2'b10;
    for (int ph = 0; ph < 4; ph++) begin
      sig_in[2] = ~sig_in[2];
      for (int k = 0; k < 8; k++) begin
        cyc(1);
        if (pulse_o[2]) begin
          np++;
          if (level_o[2]) bad++;
        end
      end
    end
    n_tests++;
    if (np != 2 || bad != 0 || cnt_o[2*CNT_W +: CNT_W] !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL mode_fall_only: pulses=%0d on_rise=%0d cnt2=%0d, required 2, 0, 2",
               np, bad, cnt_o[2*CNT_W +: CNT_W]);
    end
    mode_i[5:4] = 2'b00;
    np = 0;
    prev = level_o[2];
    for (int ph = 0; ph < 4; ph++) begin
      sig_in[2] = ~sig_in[2];
      for (int k = 0; k < 8; k++) begin
        cyc(1);
        np += int'(pulse_o[2]);
        if (level_o[2] !== prev) ntog++;
        prev = level_o[2];
      end
    end
    n_tests++;
    if (ntog != 4 || np != 0 || cnt_o[2*CNT_W +: CNT_W] !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL mode_off: level_toggles=%0d pulses=%0d cnt2=%0d, required 4, 0, 2",
               ntog, np, cnt_o[2*CNT_W +: CNT_W]);
    end
  endtask

  task automatic test_sat_clear();
    int np = 0;
    for (int ph = 0; ph < 10; ph++) begin
      sig_in[3] = ~sig_in[3];
      for (int k = 0; k < 8; k++) begin
        cyc(1);
        np += int'(pulse_o[3]);
      end
    end
    n_tests++;
    if (np != 10 || cnt_o[3*CNT_W +: CNT_W] !== CNT_W'(CMAX) || sticky_o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: pulses=%0d cnt3=%0d sticky3=%b, required 10, %0d, 1",
               np, cnt_o[3*CNT_W +: CNT_W], sticky_o[3], CMAX);
    end
    clr_i[3] = 1'b1; cyc(1); clr_i[3] = 1'b0;
    n_tests++;
    if (cnt_o[3*CNT_W +: CNT_W] !== '0 || sticky_o[3] !== 1'b0 || cnt_o[2*CNT_W +: CNT_W] !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL clear_alone: cnt3=%0d sticky3=%b cnt2=%0d, required 0, 0, 2",
               cnt_o[3*CNT_W +: CNT_W], sticky_o[3], cnt_o[2*CNT_W +: CNT_W]);
    end
    sig_in[3] = 1'b1; cyc(8);
    sig_in[3] = 1'b0; cyc(6);
    clr_i[3] = 1'b1; cyc(1); clr_i[3] = 1'b0;
    n_tests++;
    if (pulse_o[3] !== 1'b1 || cnt_o[3*CNT_W +: CNT_W] !== CNT_W'(1) || sticky_o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_pulse: pulse3=%b cnt3=%0d sticky3=%b, required 1, 1, 1",
               pulse_o[3], cnt_o[3*CNT_W +: CNT_W], sticky_o[3]);
    end
    cyc(4);
  endtask

  task automatic test_async_reset();
    sig_in = '0; cyc(12);
    sig_in[0] = 1'b1; cyc(4);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (level_o !== '0 || pulse_o !== '0 || sticky_o !== '0 || cnt_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: level=%b pulse=%b sticky=%b cnt=%h, required all zero",
               level_o, pulse_o, sticky_o, cnt_o);
    end
    cyc(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      n_tests++;
      if (level_o[0] !== (k >= 6) || pulse_o[0] !== (k == 7)) begin
        n_fail++;
        $display("FAIL post_reset_latency step %0d: level0=%b pulse0=%b, required %b %b",
                 k, level_o[0], pulse_o[0], (k >= 6), (k == 7));
      end
    end
  endtask

  task automatic test_random();
    int hold [NUM_CH];
    int shown = 0;
    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    for (int c = 0; c < NUM_CH; c++) hold[c] = $urandom_range(1, 9);
    for (int t = 0; t < 3000; t++) begin
      cyc(1);
      for (int c = 0; c < NUM_CH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      n_tests += 4;
      if (level_o !== m_filt || pulse_o !== m_pulse || sticky_o !== m_sticky || cnt_o !== exp_cnt) begin
        n_fail += int'(level_o !== m_filt) + int'(pulse_o !== m_pulse)
                + int'(sticky_o !== m_sticky) + int'(cnt_o !== exp_cnt);
        if (shown < 20) begin
          shown++;
          $display("FAIL random cycle %0d: level=%b/%b pulse=%b/%b sticky=%b/%b cnt=%h/%h (got/required)",
                   t, level_o, m_filt, pulse_o, m_pulse, sticky_o, m_sticky, cnt_o, exp_cnt);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold[c] == 0) begin
          sig_in[c] = ~sig_in[c];
          hold[c] = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 63) == 0) mode_i = 8'($urandom);
      for (int c = 0; c < NUM_CH; c++) clr_i[c] = ($urandom_range(0, 31) == 0);
    end
    clr_i = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_mode();
    test_sat_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_multi_edge_det
